// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared byte counts, FSM encoding and int8 saturation helper
package conv_ctrl_pkg;
  localparam int DATA_BYTES = 64;
  localparam int W_BYTES = 27;
  localparam int OUT_BYTES = 108;
  localparam int CNT_W = 7;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, CALC, DRAIN} state_t;
  function automatic logic [7:0] sat8(input logic signed [19:0] acc);
    logic signed [11:0] s;
    s = acc[19:8];
    return s > 12'sd127 ? 8'h7f : s < -12'sd128 ? 8'h80 : s[7:0];
  endfunction
endpackage

// File: rtl/conv_module.sv
// conv_module: three 3x3 valid convolutions over an 8x8 int8 image, scaled by 1/256 and saturated
module conv_module
  import conv_ctrl_pkg::*;
(
  input  logic [DATA_BYTES-1:0][7:0] image,
  input  logic [W_BYTES-1:0][7:0]    kernel,
  output logic [OUT_BYTES-1:0][7:0]  result
);
  always_comb begin : calc
    logic signed [19:0] acc;
    logic signed [15:0] p;
    acc = '0;
    p = '0;
    result = '0;
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          acc = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              p = 16'(signed'(image[(r + i) * 8 + c + j])) * 16'(signed'(kernel[d * 9 + i * 3 + j]));
              acc = acc + 20'(p);
            end
          result[d * 36 + r * 6 + c] = sat8(acc);
        end
  end
endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: streams kernels and an image in, runs one convolution, streams 108 result bytes out
module conv_ctrl
  import conv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_w,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [W_BYTES-1:0][7:0] kernel;
  logic [DATA_BYTES-1:0][7:0] image;
  logic [OUT_BYTES-1:0][7:0] obuf, result;
  logic in_fire, out_fire, done_q;
  conv_module u_conv (.image(image), .kernel(kernel), .result(result));
  assign busy = state != IDLE;
  assign in_ready = state == LOAD_W || state == LOAD_D;
  assign out_valid = state == DRAIN;
  assign out_last = out_valid && cnt == CNT_W'(OUT_BYTES - 1);
  assign out_data = obuf[cnt];
  assign done = done_q;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = start ? (load_w ? LOAD_W : LOAD_D) : IDLE;
      LOAD_W: state_n = in_fire && cnt == CNT_W'(W_BYTES - 1) ? LOAD_D : LOAD_W;
      LOAD_D: state_n = in_fire && cnt == CNT_W'(DATA_BYTES - 1) ? CALC : LOAD_D;
      CALC:   state_n = DRAIN;
      DRAIN:  state_n = out_fire && out_last ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      kernel <= '0;
      image <= '0;
      obuf <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + CNT_W'(in_fire | out_fire);
      if (state == LOAD_W && in_fire) kernel[cnt[4:0]] <= in_data;
      if (state == LOAD_D && in_fire) image[cnt[5:0]] <= in_data;
      if (state == CALC) obuf <= result;
      done_q <= out_fire && out_last;
    end
  end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: scoreboard bench for conv_ctrl frames, stalls, aborts and ignored starts
module tb_conv_ctrl;
  import conv_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, start, load_w, busy, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [7:0] in_data, out_data;
  int n_err = 0, n_chk = 0, n_in = 0, n_out = 0, n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] kern[W_BYTES], img[DATA_BYTES], exp_b[OUT_BYTES];
  bit gaps = 0, stalls = 0, prev_last = 0, held_v = 0;
  logic [7:0] held_d;

  always #5 clk = ~clk;

  conv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_w(load_w), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_last = 0;
        held_v = 0;
      end else begin
        check("done", done, prev_last);
        if (held_v && out_valid) check("stable", out_data, held_d);
        if (in_valid && in_ready) n_in++;
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) check("extra_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
            check("out_last", out_last, exp_q.size() == 0);
          end
        end
        if (done) n_done++;
        prev_last = out_valid && out_ready && out_last;
        held_v = out_valid && !out_ready;
        held_d = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    bit rdy;
    while (gaps && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = b;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) check("in_ready_timeout", 0, 1);
  endtask

  task automatic fill(input logic [7:0] kv, input logic [7:0] iv, input logic [7:0] ev);
    foreach (kern[k]) kern[k] = kv;
    foreach (img[k]) img[k] = iv;
    foreach (exp_b[j]) exp_b[j] = ev;
  endtask

  task automatic frame(input bit lw, input bit start_in_drain);
    int t = 0;
    int d0;
    foreach (exp_b[j]) exp_q.push_back(exp_b[j]);
    start = 1'b1;
    load_w = lw;
    @(posedge clk);
    #1;
    start = 1'b0;
    load_w = 1'b0;
    check("busy_start", busy, 1);
    n_in = 0;
    n_out = 0;
    if (lw) foreach (kern[k]) send(kern[k]);
    foreach (img[k]) send(img[k]);
    in_valid = 1'b0;
    check("in_count", n_in, lw ? W_BYTES + DATA_BYTES : DATA_BYTES);
    check("in_ready_calc", in_ready, 0);
    check("lat_calc", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_drain", out_valid, 1);
    if (start_in_drain) begin
      start = 1'b1;
      load_w = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      load_w = 1'b0;
    end
    d0 = n_done;
    while (n_done == d0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", n_done, d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", n_done, d0 + 1);
    check("out_count", n_out, OUT_BYTES);
    check("q_empty", exp_q.size(), 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    load_w = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_done", done, 0);
    fill(8'h10, 8'h10, 8'h09);
    frame(1, 0);
    fill(8'h10, 8'h00, 8'h00);
    frame(0, 0);
    fill(8'h10, 8'h10, 8'h00);
    for (int k = 0; k < 9; k++) begin
      kern[k] = 8'h00;
      kern[k + 18] = 8'h00;
    end
    for (int j = 36; j < 72; j++) exp_b[j] = 8'h09;
    frame(1, 0);
    gaps = 1;
    stalls = 1;
    fill(8'h10, 8'h10, 8'h09);
    frame(1, 0);
    gaps = 0;
    stalls = 0;
    start = 1'b1;
    load_w = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    load_w = 1'b0;
    for (int k = 0; k < W_BYTES; k++) send(8'h10);
    for (int k = 0; k < 30; k++) send(8'h10);
    in_valid = 1'b0;
    d0 = n_done;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", n_done, d0);
    check("abort_idle", busy, 0);
    fill(8'h00, 8'h10, 8'h00);
    frame(0, 0);
    fill(8'hF0, 8'h10, 8'hF7);
    frame(1, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
